// File: rtl/bk_serial_subtractor16.sv
// bk_serial_subtractor16: multi-word unsigned A - B, one 16-bit word per cycle,
// least-significant word first. Two-stage pipeline (S1 operands, S2 result)
// with a 16-bit Brent-Kung prefix core between them and the borrow chained
// word-to-word through a registered carry.
module bk_serial_subtractor16 #(
  parameter int unsigned WORDS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] diff,
  output logic        out_last,
  output logic        out_borrow,
  output logic        out_zero
);

  localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

  // Input word counter and S1 stage
  logic [2:0]  cnt_q;
  logic        s1_valid_q;
  logic [15:0] s1_a_q;
  logic [15:0] s1_nb_q;
  logic [2:0]  s1_idx_q;

  // S2 stage and inter-word state
  logic        s2_valid_q;
  logic [15:0] diff_q;
  logic        last_q;
  logic        borrow_q;
  logic        zero_q;
  logic        carry_q;
  logic        zacc_q;

  // Handshake and core signals
  logic        s2_adv;
  logic        accept;
  logic        cin;
  logic [15:0] pg_w;
  logic [15:0] g_w;
  logic [15:0] p_w;
  logic [15:0] sum_d;
  logic        cout_d;
  logic        zero_d;
  logic        last_d;
  logic [2:0]  cnt_d;

  assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;
  assign cin      = (s1_idx_q == '0) ? 1'b1 : carry_q;
  assign last_d   = (s1_idx_q == LAST_IDX);
  assign zero_d   = (s1_idx_q == '0) ? (sum_d == '0) : (zacc_q && (sum_d == '0));
  assign cnt_d    = (cnt_q == LAST_IDX) ? '0 : cnt_q + 3'd1;

  // Brent-Kung prefix over a + ~b + cin; cin is folded into bit 0 generate so
  // the group generate at bit i is directly the carry into bit i+1.
  always_comb begin
    int unsigned s;
    pg_w    = s1_a_q ^ s1_nb_q;
    g_w     = s1_a_q & s1_nb_q;
    p_w     = pg_w;
    g_w[0]  = g_w[0] | (p_w[0] & cin);
    s       = 1;
    // up-sweep: 4 levels, node i combines with i-s when (i+1) is a multiple of 2s
    for (int unsigned lvl = 0; lvl < 4; lvl++) begin
      s = 32'd1 << lvl;
      for (int unsigned i = 0; i < 16; i++) begin
        if (((i + 1) % (2 * s)) == 0) begin
          g_w[i] = g_w[i] | (p_w[i] & g_w[i - s]);
          p_w[i] = p_w[i] & p_w[i - s];
        end
      end
    end
    // down-sweep: 3 levels filling the remaining prefixes (11; 5,9,13; evens)
    for (int unsigned lvl = 0; lvl < 3; lvl++) begin
      s = 32'd4 >> lvl;
      for (int unsigned i = 0; i < 16; i++) begin
        if ((((i + 1) % (2 * s)) == s) && (i >= 2 * s)) begin
          g_w[i] = g_w[i] | (p_w[i] & g_w[i - s]);
          p_w[i] = p_w[i] & p_w[i - s];
        end
      end
    end
    sum_d  = pg_w ^ {g_w[14:0], cin};
    cout_d = g_w[15];
  end

  // Input counter and S1 operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_nb_q    <= '0;
      s1_idx_q   <= '0;
    end else begin
      if (accept) begin
        cnt_q      <= cnt_d;
        s1_valid_q <= 1'b1;
        s1_a_q     <= a;
        s1_nb_q    <= ~b;
        s1_idx_q   <= cnt_q;
      end else if (s2_adv) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  // S2 result register plus chained carry and zero accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      last_q     <= 1'b0;
      borrow_q   <= 1'b0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      zacc_q     <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= 1'b1;
        diff_q     <= sum_d;
        last_q     <= last_d;
        borrow_q   <= last_d & ~cout_d;
        zero_q     <= last_d & zero_d;
        carry_q    <= cout_d;
        zacc_q     <= zero_d;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign diff       = diff_q;
  assign out_last   = last_q;
  assign out_borrow = borrow_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_bk_serial_subtractor16.sv
// Bench for bk_serial_subtractor16: one WORDS=1 and one WORDS=2 instance,
// directed scenarios plus randomized streams against a wide-integer model.
module tb_bk_serial_subtractor16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic [15:0] a          [2];
  logic [15:0] b          [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [15:0] diff       [2];
  logic        out_last   [2];
  logic        out_borrow [2];
  logic        out_zero   [2];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [127:0] d;
    logic         bw;
    logic         z;
  } op_t;

  op_t          expq0[$];
  op_t          expq1[$];
  logic [127:0] acc_a [2];
  logic [127:0] acc_b [2];
  logic [127:0] got_d [2];
  int unsigned  icnt  [2];
  int unsigned  ocnt  [2];

  always #5 clk = ~clk;

  bk_serial_subtractor16 #(.WORDS(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]), .b(b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .diff(diff[0]),
    .out_last(out_last[0]), .out_borrow(out_borrow[0]), .out_zero(out_zero[0])
  );

  bk_serial_subtractor16 #(.WORDS(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]), .b(b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .diff(diff[1]),
    .out_last(out_last[1]), .out_borrow(out_borrow[1]), .out_zero(out_zero[1])
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned words_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // Model: gather whole operands as wide integers, subtract once the last
  // word arrives, and compare against the assembled output operation.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq0.delete();
      expq1.delete();
      for (int k = 0; k < 2; k++) begin
        acc_a[k] = '0; acc_b[k] = '0; got_d[k] = '0; icnt[k] = 0; ocnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int unsigned w;
        op_t o;
        op_t e;
        logic have;
        logic [127:0] mask;
        w = words_of(k);
        if (in_valid[k] && in_ready[k]) begin
          acc_a[k] = acc_a[k] | (128'(a[k]) << (16 * icnt[k]));
          acc_b[k] = acc_b[k] | (128'(b[k]) << (16 * icnt[k]));
          icnt[k]++;
          if (icnt[k] == w) begin
            mask = (128'd1 << (16 * w)) - 128'd1;
            o.d  = (acc_a[k] - acc_b[k]) & mask;
            o.bw = (acc_a[k] < acc_b[k]);
            o.z  = (o.d == '0);
            if (k == 0) expq0.push_back(o); else expq1.push_back(o);
            acc_a[k] = '0; acc_b[k] = '0; icnt[k] = 0;
          end
        end
        if (out_valid[k] && out_ready[k]) begin
          chk("out_last", out_last[k], ocnt[k] == w - 1);
          got_d[k] = got_d[k] | (128'(diff[k]) << (16 * ocnt[k]));
          if (ocnt[k] == w - 1) begin
            have = 1'b0;
            if (k == 0 && expq0.size() > 0) begin e = expq0.pop_front(); have = 1'b1; end
            if (k == 1 && expq1.size() > 0) begin e = expq1.pop_front(); have = 1'b1; end
            chk("op_expected", have, 1'b1);
            if (have) begin
              chk("op_diff", got_d[k], e.d);
              chk("op_borrow", out_borrow[k], e.bw);
              chk("op_zero", out_zero[k], e.z);
            end
            got_d[k] = '0;
            ocnt[k]  = 0;
          end else begin
            chk("mid_borrow", out_borrow[k], 1'b0);
            chk("mid_zero", out_zero[k], 1'b0);
            ocnt[k]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk(input int k);
    chk("rst_in_ready", in_ready[k], 1'b1);
    chk("rst_out_valid", out_valid[k], 1'b0);
    chk("rst_diff", diff[k], 16'h0);
    chk("rst_last", out_last[k], 1'b0);
    chk("rst_borrow", out_borrow[k], 1'b0);
    chk("rst_zero", out_zero[k], 1'b0);
  endtask

  // One isolated word on an idle instance; result must show after two edges.
  task automatic lat_word(input int k, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] ed, input logic el, input logic eb, input logic ez);
    tick();
    in_valid[k] = 1'b1; a[k] = av; b[k] = bv;
    chk("lat_in_ready", in_ready[k], 1'b1);
    tick();
    in_valid[k] = 1'b0;
    chk("lat_early_valid", out_valid[k], 1'b0);
    tick();
    chk("lat_valid", out_valid[k], 1'b1);
    chk("lat_diff", diff[k], ed);
    chk("lat_last", out_last[k], el);
    chk("lat_borrow", out_borrow[k], eb);
    chk("lat_zero", out_zero[k], ez);
    tick();
  endtask

  task automatic rand_word(input int k);
    a[k] = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       b[k] = a[k];
      1:       b[k] = 16'($urandom_range(0, 3));
      default: b[k] = 16'($urandom);
    endcase
  endtask

  task automatic rand_stream(input int k, input int unsigned n);
    int unsigned sent = 0;
    int unsigned cyc  = 0;
    logic acc;
    tick();
    in_valid[k]  = ($urandom_range(0, 3) != 0);
    out_ready[k] = ($urandom_range(0, 3) != 0);
    rand_word(k);
    while (sent < n) begin
      @(negedge clk);
      acc = in_valid[k] && in_ready[k];
      tick();
      cyc++;
      if (acc) sent++;
      out_ready[k] = ($urandom_range(0, 3) != 0);
      if (sent >= n) begin
        in_valid[k] = 1'b0;
      end else if (acc || !in_valid[k]) begin
        in_valid[k] = ($urandom_range(0, 3) != 0);
        rand_word(k);
      end
      if (cyc > 40 * n + 100) begin
        chk("stream_timeout", sent, n);
        in_valid[k] = 1'b0;
        break;
      end
    end
    in_valid[k] = 1'b0;
  endtask

  task automatic drain();
    int unsigned cyc = 0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    while ((expq0.size() != 0 || expq1.size() != 0 || out_valid[0] || out_valid[1]) && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("drain_done", cyc < 100, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned acc_n;
    int unsigned cyc;
    logic [15:0] snap;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; a[k] = '0; b[k] = '0; out_ready[k] = 1'b1;
    end
    tick();
    tick();
    reset_chk(0);
    reset_chk(1);
    rst_n = 1'b1;

    // WORDS=1 plain difference and underflow
    lat_word(0, 16'h1234, 16'h0234, 16'h1000, 1'b1, 1'b0, 1'b0);
    lat_word(0, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b1, 1'b0);

    // WORDS=2 borrow from word 0 into word 1
    tick();
    in_valid[1] = 1'b1; a[1] = 16'h0000; b[1] = 16'h0001;
    tick();
    a[1] = 16'h0001; b[1] = 16'h0000;
    tick();
    in_valid[1] = 1'b0;
    chk("bp2_w0_valid", out_valid[1], 1'b1);
    chk("bp2_w0_diff", diff[1], 16'hFFFF);
    chk("bp2_w0_last", out_last[1], 1'b0);
    tick();
    chk("bp2_w1_diff", diff[1], 16'h0000);
    chk("bp2_w1_last", out_last[1], 1'b1);
    chk("bp2_w1_borrow", out_borrow[1], 1'b0);
    chk("bp2_w1_zero", out_zero[1], 1'b0);
    tick();

    // Equal operands with a gap between the two words
    tick();
    in_valid[1] = 1'b1; a[1] = 16'h1234; b[1] = 16'h1234;
    tick();
    in_valid[1] = 1'b0;
    tick(); tick(); tick();
    in_valid[1] = 1'b1; a[1] = 16'hABCD; b[1] = 16'hABCD;
    tick();
    in_valid[1] = 1'b0;
    tick();
    chk("eq_diff", diff[1], 16'h0000);
    chk("eq_last", out_last[1], 1'b1);
    chk("eq_zero", out_zero[1], 1'b1);
    chk("eq_borrow", out_borrow[1], 1'b0);
    tick();

    // Back-pressure: out_ready low for 4 cycles under a continuous stream
    tick();
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    rand_word(1);
    acc_n = 0;
    snap  = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (in_valid[1] && in_ready[1]) begin
        acc_n++;
        tick();
        rand_word(1);
      end else begin
        tick();
      end
      if (c == 1) snap = diff[1];
    end
    chk("bkp_accepted", acc_n, 2);
    chk("bkp_in_ready", in_ready[1], 1'b0);
    chk("bkp_out_valid", out_valid[1], 1'b1);
    chk("bkp_hold", diff[1], snap);
    out_ready[1] = 1'b1;
    cyc = 0;
    while (acc_n < 4 && cyc < 50) begin
      @(negedge clk);
      if (in_valid[1] && in_ready[1]) begin
        acc_n++;
        tick();
        rand_word(1);
      end else begin
        tick();
      end
      cyc++;
    end
    in_valid[1] = 1'b0;
    chk("bkp_all_accepted", acc_n, 4);
    drain();

    // Reset after the first word of an operation
    tick();
    in_valid[1] = 1'b1; a[1] = 16'h7777; b[1] = 16'h0001;
    tick();
    in_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_chk(1);
    tick();
    rst_n = 1'b1;
    tick();
    in_valid[1] = 1'b1; a[1] = 16'h0005; b[1] = 16'h0003;
    tick();
    a[1] = 16'h0000; b[1] = 16'h0000;
    tick();
    in_valid[1] = 1'b0;
    chk("rst_w0_diff", diff[1], 16'h0002);
    chk("rst_w0_last", out_last[1], 1'b0);
    tick();
    chk("rst_w1_diff", diff[1], 16'h0000);
    chk("rst_w1_last", out_last[1], 1'b1);
    chk("rst_w1_borrow", out_borrow[1], 1'b0);
    tick();

    // Randomized traffic on both instances
    fork
      rand_stream(0, 2000);
      rand_stream(1, 10000);
    join
    drain();
    chk("end_q0", expq0.size(), 0);
    chk("end_q1", expq1.size(), 0);
    chk("end_in_partial", icnt[1], 0);
    chk("end_out_partial", ocnt[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
